// File: rtl/mem_pipe_if.sv
// mem_pipe_if -- data-memory request/response bus used by the MEM stage.
//   dmem_req_o    : request strobe, high while a load/store is outstanding
//   dmem_we_o     : 1 = store, 0 = load
//   dmem_addr_o   : byte address of the access
//   dmem_wdata_o  : store data
//   dmem_ack_i    : completion strobe from memory
//   dmem_rdata_i  : load data, valid in the ack cycle
// master = pipeline side, slave = memory side.
interface mem_pipe_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    input  dmem_ack_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    output dmem_ack_i, dmem_rdata_i
  );
endinterface

// File: rtl/mem_pipe.sv
// mem_pipe -- MEM stage of a five-stage pipeline: EX/MEM and MEM/WB
// registers, data-memory handshake, stall generation and a timeout monitor.
//   clk_i, rst_i          : rising-edge clock, synchronous active-high reset
//   ex_*_i                : instruction leaving EX (valid, control, rd, ALU, store data)
//   dmem                  : data-memory bus (mem_pipe_if.master)
//   stall_o               : freezes PC, IF/ID and ID/EX while memory is busy
//   EXMEM_*_o / MEMWB_*_o : forwarding views and register-file write port
//   err_o                 : sticky flag, set once a request has waited 15 cycles
module mem_pipe (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ex_valid_i,
  input  logic              ex_rw_i,
  input  logic              ex_memtoreg_i,
  input  logic              ex_memread_i,
  input  logic              ex_memwrite_i,
  input  logic [4:0]        ex_rd_i,
  input  logic [31:0]       ex_alu_i,
  input  logic [31:0]       ex_wdata_i,
  mem_pipe_if.master        dmem,
  output logic              stall_o,
  output logic              EXMEM_rw_o,
  output logic [4:0]        EXMEM_rd_o,
  output logic [31:0]       EXMEM_data_o,
  output logic              MEMWB_rw_o,
  output logic [4:0]        MEMWB_rd_o,
  output logic [31:0]       MEMWB_data_o,
  output logic              err_o
);

  typedef enum logic {IDLE, WAIT} state_t;

  logic        r_exMemValid;
  logic        r_exMemRw;
  logic        r_exMemMemToReg;
  logic        r_exMemMemRead;
  logic        r_exMemMemWrite;
  logic [4:0]  r_exMemRd;
  logic [31:0] r_exMemAlu;
  logic [31:0] r_exMemWdata;

  logic        r_memWbValid;
  logic        r_memWbRw;
  logic        r_memWbMemToReg;
  logic        r_memWbMemRead;
  logic        r_memWbMemWrite;
  logic [4:0]  r_memWbRd;
  logic [31:0] r_memWbData;

  state_t      r_state;
  logic [3:0]  r_waitCnt;
  logic        r_err;

  logic        w_memOp;
  logic        w_ack;
  logic        w_stall;
  logic [31:0] w_wbData;
  state_t      w_nextState;
  logic [3:0]  w_nextCnt;
  logic        w_nextErr;
  logic        w_unusedMemWb;

  // An ack only counts while a request is actually presented.
  assign w_memOp  = r_exMemValid & (r_exMemMemRead | r_exMemMemWrite);
  assign w_ack    = w_memOp & dmem.dmem_ack_i;
  assign w_stall  = w_memOp & ~dmem.dmem_ack_i;
  assign w_wbData = (r_exMemMemToReg & r_exMemMemRead) ? dmem.dmem_rdata_i : r_exMemAlu;

  assign dmem.dmem_req_o   = w_memOp;
  assign dmem.dmem_we_o    = r_exMemMemWrite;
  assign dmem.dmem_addr_o  = r_exMemAlu;
  assign dmem.dmem_wdata_o = r_exMemWdata;

  assign stall_o      = w_stall;
  assign EXMEM_rw_o   = r_exMemValid & r_exMemRw;
  assign EXMEM_rd_o   = r_exMemRd;
  assign EXMEM_data_o = r_exMemAlu;
  assign MEMWB_rw_o   = r_memWbValid & r_memWbRw;
  assign MEMWB_rd_o   = r_memWbRd;
  assign MEMWB_data_o = r_memWbData;
  assign err_o        = r_err;

  // MEM/WB memory-control bits are carried for completeness but nothing
  // downstream of this block consumes them yet.
  assign w_unusedMemWb = &{1'b0, r_memWbMemToReg, r_memWbMemRead, r_memWbMemWrite};

  // Wait-state tracking: the counter runs only while parked in WAIT and
  // saturates, so err sets once and the request simply stays outstanding.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_waitCnt;
    w_nextErr   = r_err;
    case (r_state)
      IDLE: begin
        w_nextCnt = 4'd0;
        if (w_memOp && !w_ack) w_nextState = WAIT;
      end
      WAIT: begin
        if (w_ack) begin
          w_nextState = IDLE;
          w_nextCnt   = 4'd0;
        end else if (r_waitCnt != 4'hF) begin
          w_nextCnt = r_waitCnt + 4'd1;
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextCnt   = 4'd0;
      end
    endcase
    if (w_nextCnt == 4'hF) w_nextErr = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_waitCnt <= 4'd0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_nextCnt;
      r_err     <= w_nextErr;
    end
  end

  // Pipeline registers: EX/MEM freezes during a stall while MEM/WB takes a
  // bubble, so the stalled instruction writes back exactly once.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_exMemValid    <= 1'b0;
      r_exMemRw       <= 1'b0;
      r_exMemMemToReg <= 1'b0;
      r_exMemMemRead  <= 1'b0;
      r_exMemMemWrite <= 1'b0;
      r_exMemRd       <= 5'd0;
      r_exMemAlu      <= 32'd0;
      r_exMemWdata    <= 32'd0;
      r_memWbValid    <= 1'b0;
      r_memWbRw       <= 1'b0;
      r_memWbMemToReg <= 1'b0;
      r_memWbMemRead  <= 1'b0;
      r_memWbMemWrite <= 1'b0;
      r_memWbRd       <= 5'd0;
      r_memWbData     <= 32'd0;
    end else if (!w_stall) begin
      r_exMemValid    <= ex_valid_i;
      r_exMemRw       <= ex_rw_i;
      r_exMemMemToReg <= ex_memtoreg_i;
      r_exMemMemRead  <= ex_memread_i;
      r_exMemMemWrite <= ex_memwrite_i;
      r_exMemRd       <= ex_rd_i;
      r_exMemAlu      <= ex_alu_i;
      r_exMemWdata    <= ex_wdata_i;
      r_memWbValid    <= r_exMemValid;
      r_memWbRw       <= r_exMemRw;
      r_memWbMemToReg <= r_exMemMemToReg;
      r_memWbMemRead  <= r_exMemMemRead;
      r_memWbMemWrite <= r_exMemMemWrite;
      r_memWbRd       <= r_exMemRd;
      r_memWbData     <= w_wbData;
    end else begin
      r_memWbValid    <= 1'b0;
      r_memWbRw       <= 1'b0;
      r_memWbMemToReg <= 1'b0;
      r_memWbMemRead  <= 1'b0;
      r_memWbMemWrite <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_pipe.sv
// tb_mem_pipe -- directed self-checking bench for mem_pipe. Inputs change
// 1ns after the rising edge, outputs are sampled on the falling edge.
module tb_mem_pipe;

  logic        clk;
  logic        rst;
  logic        exValid;
  logic        exRw;
  logic        exMemToReg;
  logic        exMemRead;
  logic        exMemWrite;
  logic [4:0]  exRd;
  logic [31:0] exAlu;
  logic [31:0] exWdata;
  logic        stall;
  logic        exMemRw;
  logic [4:0]  exMemRd;
  logic [31:0] exMemData;
  logic        memWbRw;
  logic [4:0]  memWbRd;
  logic [31:0] memWbData;
  logic        err;

  int compareCount;
  int mismatchCount;

  mem_pipe_if dmemBus ();

  mem_pipe dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .ex_valid_i    (exValid),
    .ex_rw_i       (exRw),
    .ex_memtoreg_i (exMemToReg),
    .ex_memread_i  (exMemRead),
    .ex_memwrite_i (exMemWrite),
    .ex_rd_i       (exRd),
    .ex_alu_i      (exAlu),
    .ex_wdata_i    (exWdata),
    .dmem          (dmemBus.master),
    .stall_o       (stall),
    .EXMEM_rw_o    (exMemRw),
    .EXMEM_rd_o    (exMemRd),
    .EXMEM_data_o  (exMemData),
    .MEMWB_rw_o    (memWbRw),
    .MEMWB_rd_o    (memWbRd),
    .MEMWB_data_o  (memWbData),
    .err_o         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic rw, input logic m2r,
                               input logic rd_en, input logic wr_en,
                               input logic [4:0] rd, input logic [31:0] alu,
                               input logic [31:0] wdata);
    exValid    = v;
    exRw       = rw;
    exMemToReg = m2r;
    exMemRead  = rd_en;
    exMemWrite = wr_en;
    exRd       = rd;
    exAlu      = alu;
    exWdata    = wdata;
  endtask

  task automatic applyBubble();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rst = 1'b1;
    dmemBus.dmem_ack_i   = 1'b0;
    dmemBus.dmem_rdata_i = 32'd0;
    applyBubble();
    nextCycle();
    nextCycle();

    // Reset state
    @(negedge clk);
    checkOutput("rstReq",     32'(dmemBus.dmem_req_o), 32'd0);
    checkOutput("rstStall",   32'(stall), 32'd0);
    checkOutput("rstExMemRw", 32'(exMemRw), 32'd0);
    checkOutput("rstMemWbRw", 32'(memWbRw), 32'd0);
    checkOutput("rstErr",     32'(err), 32'd0);
    nextCycle();
    rst = 1'b0;

    // ALU op flows through both registers without stalling
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h10, 32'd0);
    nextCycle();
    applyBubble();
    @(negedge clk);
    checkOutput("aluExMemRw",   32'(exMemRw), 32'd1);
    checkOutput("aluExMemRd",   32'(exMemRd), 32'd5);
    checkOutput("aluExMemData", exMemData, 32'h10);
    checkOutput("aluReq",       32'(dmemBus.dmem_req_o), 32'd0);
    checkOutput("aluStall",     32'(stall), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("aluMemWbRw",   32'(memWbRw), 32'd1);
    checkOutput("aluMemWbRd",   32'(memWbRd), 32'd5);
    checkOutput("aluMemWbData", memWbData, 32'h10);

    // rd = 0 passes through untouched
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h77, 32'd0);
    nextCycle();
    applyBubble();
    @(negedge clk);
    checkOutput("rd0ExMemRw", 32'(exMemRw), 32'd1);
    checkOutput("rd0ExMemRd", 32'(exMemRd), 32'd0);
    nextCycle();

    // Load with ack held off for 3 cycles
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 32'h40, 32'd0);
    nextCycle();
    applyBubble();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("ldWaitReq",    32'(dmemBus.dmem_req_o), 32'd1);
      checkOutput("ldWaitStall",  32'(stall), 32'd1);
      checkOutput("ldWaitAddr",   dmemBus.dmem_addr_o, 32'h40);
      checkOutput("ldWaitWe",     32'(dmemBus.dmem_we_o), 32'd0);
      checkOutput("ldWaitMemWb",  32'(memWbRw), 32'd0);
      nextCycle();
    end
    dmemBus.dmem_ack_i   = 1'b1;
    dmemBus.dmem_rdata_i = 32'hDEADBEEF;
    @(negedge clk);
    checkOutput("ldAckReq",   32'(dmemBus.dmem_req_o), 32'd1);
    checkOutput("ldAckStall", 32'(stall), 32'd0);
    nextCycle();
    dmemBus.dmem_ack_i   = 1'b0;
    dmemBus.dmem_rdata_i = 32'd0;
    @(negedge clk);
    checkOutput("ldMemWbRw",   32'(memWbRw), 32'd1);
    checkOutput("ldMemWbRd",   32'(memWbRd), 32'd3);
    checkOutput("ldMemWbData", memWbData, 32'hDEADBEEF);
    checkOutput("ldDoneReq",   32'(dmemBus.dmem_req_o), 32'd0);

    // Store acked in its first cycle
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h8, 32'h1234);
    nextCycle();
    applyBubble();
    dmemBus.dmem_ack_i = 1'b1;
    @(negedge clk);
    checkOutput("stReq",   32'(dmemBus.dmem_req_o), 32'd1);
    checkOutput("stWe",    32'(dmemBus.dmem_we_o), 32'd1);
    checkOutput("stAddr",  dmemBus.dmem_addr_o, 32'h8);
    checkOutput("stWdata", dmemBus.dmem_wdata_o, 32'h1234);
    checkOutput("stStall", 32'(stall), 32'd0);
    nextCycle();
    dmemBus.dmem_ack_i = 1'b0;
    @(negedge clk);
    checkOutput("stDoneReq",  32'(dmemBus.dmem_req_o), 32'd0);
    checkOutput("stMemWbRw",  32'(memWbRw), 32'd0);
    checkOutput("stDoneStall", 32'(stall), 32'd0);

    // Back-to-back load then store, each acked immediately
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 32'h100, 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h200, 32'hCAFE);
    dmemBus.dmem_ack_i   = 1'b1;
    dmemBus.dmem_rdata_i = 32'h55AA;
    @(negedge clk);
    checkOutput("b2bLdReq",   32'(dmemBus.dmem_req_o), 32'd1);
    checkOutput("b2bLdWe",    32'(dmemBus.dmem_we_o), 32'd0);
    checkOutput("b2bLdAddr",  dmemBus.dmem_addr_o, 32'h100);
    checkOutput("b2bLdStall", 32'(stall), 32'd0);
    nextCycle();
    applyBubble();
    dmemBus.dmem_rdata_i = 32'd0;
    @(negedge clk);
    checkOutput("b2bStReq",    32'(dmemBus.dmem_req_o), 32'd1);
    checkOutput("b2bStWe",     32'(dmemBus.dmem_we_o), 32'd1);
    checkOutput("b2bStAddr",   dmemBus.dmem_addr_o, 32'h200);
    checkOutput("b2bStWdata",  dmemBus.dmem_wdata_o, 32'hCAFE);
    checkOutput("b2bLdWbRw",   32'(memWbRw), 32'd1);
    checkOutput("b2bLdWbRd",   32'(memWbRd), 32'd9);
    checkOutput("b2bLdWbData", memWbData, 32'h55AA);
    nextCycle();
    dmemBus.dmem_ack_i = 1'b0;
    @(negedge clk);
    checkOutput("b2bDoneReq", 32'(dmemBus.dmem_req_o), 32'd0);
    checkOutput("b2bStWbRw",  32'(memWbRw), 32'd0);

    // Bubble with live-looking control bits issues nothing
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 32'h300, 32'd0);
    nextCycle();
    applyBubble();
    @(negedge clk);
    checkOutput("bubExMemRw", 32'(exMemRw), 32'd0);
    checkOutput("bubReq",     32'(dmemBus.dmem_req_o), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("bubMemWbRw", 32'(memWbRw), 32'd0);

    // Timeout: err must stay low early in the wait and be set well past 15 cycles
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 32'h80, 32'd0);
    nextCycle();
    applyBubble();
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 10) checkOutput("toErrEarly", 32'(err), 32'd0);
      if (i == 20) begin
        checkOutput("toErrSet",   32'(err), 32'd1);
        checkOutput("toStillReq", 32'(dmemBus.dmem_req_o), 32'd1);
        checkOutput("toStall",    32'(stall), 32'd1);
      end
      nextCycle();
    end
    dmemBus.dmem_ack_i   = 1'b1;
    dmemBus.dmem_rdata_i = 32'h13579BDF;
    @(negedge clk);
    checkOutput("toAckStall", 32'(stall), 32'd0);
    nextCycle();
    dmemBus.dmem_ack_i   = 1'b0;
    dmemBus.dmem_rdata_i = 32'd0;
    @(negedge clk);
    checkOutput("toWbRw",    32'(memWbRw), 32'd1);
    checkOutput("toWbData",  memWbData, 32'h13579BDF);
    checkOutput("toErrHeld", 32'(err), 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("toErrSticky", 32'(err), 32'd1);

    // Reset while a load is waiting; a late ack must be ignored
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6, 32'hC0, 32'd0);
    nextCycle();
    applyBubble();
    @(negedge clk);
    checkOutput("rwPendStall", 32'(stall), 32'd1);
    nextCycle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    dmemBus.dmem_ack_i   = 1'b1;
    dmemBus.dmem_rdata_i = 32'hFFFF;
    @(negedge clk);
    checkOutput("rwReq",     32'(dmemBus.dmem_req_o), 32'd0);
    checkOutput("rwStall",   32'(stall), 32'd0);
    checkOutput("rwExMemRw", 32'(exMemRw), 32'd0);
    checkOutput("rwMemWbRw", 32'(memWbRw), 32'd0);
    checkOutput("rwErr",     32'(err), 32'd0);
    nextCycle();
    dmemBus.dmem_ack_i   = 1'b0;
    dmemBus.dmem_rdata_i = 32'd0;
    @(negedge clk);
    checkOutput("rwLateReq",   32'(dmemBus.dmem_req_o), 32'd0);
    checkOutput("rwLateMemWb", 32'(memWbRw), 32'd0);
    checkOutput("rwLateStall", 32'(stall), 32'd0);
    checkOutput("rwLateErr",   32'(err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
